// File: rtl/mips_multicycle_ctrl_if.sv
// Shared memory port between the multicycle sequencer and memory.
// One request in flight; mem_ready completes it.
interface mips_multicycle_ctrl_if;
    logic mem_req;
    logic mem_wr;
    logic mem_sel_data;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_sel_data,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_sel_data,
        output mem_ready
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB, HALT on error.
// Optional retired-instruction counter enabled by MC_INSTRET_EN.
module mips_multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
`ifdef MC_INSTRET_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master mem,
    input  logic                  except,
    input  logic [1:0]            control_type,
    input  logic                  writeenable,
    input  logic                  mem_read,
    input  logic                  word_we,
    input  logic                  byte_we,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic [1:0]            pc_src,
    output logic                  rf_we,
    output logic [2:0]            state,
    output logic                  halted,
    output logic                  bus_err
`ifdef MC_INSTRET_EN
    ,
    output logic [CNT_W-1:0]      instret
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } st_t;

    st_t            st_q;
    st_t            st_d;
    logic [TO_W-1:0] to_q;
    logic [1:0]     ct_q;
    logic           wen_q;
    logic           ld_q;
    logic           sww_q;
    logic           swb_q;
    logic           req_q;
    logic           sel_q;
    logic           wr_q;
    logic           pcw_q;
    logic           rfw_q;
    logic [1:0]     pcs_q;
    logic           hlt_q;
    logic           be_q;
    logic           ready;
    logic           expire;
    logic           is_st;

    assign ready  = mem.mem_ready;
    assign is_st  = sww_q | swb_q;
    // Counter hits TIMEOUT on this cycle's wait; a same-cycle ready takes precedence.
    assign expire = (to_q == TO_W'(TIMEOUT - 1)) & ~ready;

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            FETCH: begin
                if (ready)
                    st_d = DECODE;
                else if (expire)
                    st_d = HALT;
            end
            DECODE: st_d = except ? HALT : EXEC;
            EXEC:   st_d = (ld_q | is_st) ? MEM : WB;
            MEM: begin
                if (ready)
                    st_d = WB;
                else if (expire)
                    st_d = HALT;
            end
            WB:     st_d = FETCH;
            default: st_d = HALT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q  <= FETCH;
            to_q  <= '0;
            ct_q  <= '0;
            wen_q <= 1'b0;
            ld_q  <= 1'b0;
            sww_q <= 1'b0;
            swb_q <= 1'b0;
            req_q <= 1'b1;
            sel_q <= 1'b0;
            wr_q  <= 1'b0;
            pcw_q <= 1'b0;
            rfw_q <= 1'b0;
            pcs_q <= '0;
            hlt_q <= 1'b0;
            be_q  <= 1'b0;
        end else begin
            st_q <= st_d;
            if (st_q == DECODE) begin
                ct_q  <= control_type;
                wen_q <= writeenable;
                ld_q  <= mem_read;
                sww_q <= word_we;
                swb_q <= byte_we;
            end
            if (st_d != st_q && (st_d == FETCH || st_d == MEM))
                to_q <= '0;
            else if (req_q & ~ready)
                to_q <= to_q + 1'b1;
            if ((st_q == FETCH || st_q == MEM) && st_d == HALT)
                be_q <= 1'b1;
            // Outputs registered from the next state keep them purely Moore.
            req_q <= (st_d == FETCH) || (st_d == MEM);
            sel_q <= (st_d == MEM);
            wr_q  <= (st_d == MEM) & is_st;
            pcw_q <= (st_d == WB);
            rfw_q <= (st_d == WB) & wen_q & ~is_st;
            pcs_q <= (st_d == WB) ? ct_q : 2'b00;
            hlt_q <= (st_d == HALT);
        end
    end

`ifdef MC_INSTRET_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            instret <= '0;
        else if (st_q == WB)
            instret <= instret + 1'b1;
    end
`endif

    assign mem.mem_req      = req_q;
    assign mem.mem_sel_data = sel_q;
    assign mem.mem_wr       = wr_q;
    assign ir_we            = (st_q == FETCH) & ready;
    assign pc_we            = pcw_q;
    assign rf_we            = rfw_q;
    assign pc_src           = pcs_q;
    assign state            = st_q;
    assign halted           = hlt_q;
    assign bus_err          = be_q;

endmodule
